edit_sequencer: RTL and testbench
=================================

# edit_sequencer

Sequences the alarm-time editing session for the alarm clock: turns debounced key levels into an edit-mode state machine, a wrapping field selector, and single-cycle increment/decrement strobes for the selected digit counter, with optional auto-repeat and an inactivity timeout. It sits between the key debouncers and the per-field wrap counters and alarm register.

## Interface
- `FIELDS`, default 4: number of editable fields; `field_sel` wraps over 0..FIELDS-1.
- `REPEAT_DELAY`, default 500: cycles from a press to the first auto-repeat strobe.
- `REPEAT_PERIOD`, default 100: cycles between subsequent auto-repeat strobes.
- `TIMEOUT`, default 10000: cycles with no key activity in edit before automatic cancel.
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `key_set` in 1: debounced level; enters edit mode, and commits when already editing.
- `key_back` in 1: debounced level; cancels edit.
- `key_left`, `key_right` in 1 each: debounced levels; move the field selector.
- `key_up`, `key_down` in 1 each: debounced levels; adjust the selected field.
- `editing` out 1: high while in EDIT.
- `field_sel` out $clog2(FIELDS): selected field index.
- `value_inc`, `value_dec` out 1: one-cycle strobes to the selected field counter.
- `commit` out 1: one-cycle strobe; load the edited value into the alarm register.
- `cancel` out 1: one-cycle strobe; discard the edit.

## Operation
- Each key has a registered previous sample. A press is detected when the current sample is 1 and the previous sample is 0.
- Two states, IDLE and EDIT. All outputs are registered.
- **In IDLE:**
  - A set press moves to EDIT, with `field_sel`=0 and the timeout counter cleared.
  - All other keys are ignored.
- **In EDIT, priority per cycle:** set press > back press > timeout > left/right press > up/down press/repeat.
  - Set press: `commit`=1 for one cycle, then go to IDLE.
  - Back press: `cancel`=1 for one cycle, then go to IDLE.
  - Timeout counter reaching TIMEOUT-1: `cancel`=1, then go to IDLE.
  - Right press: `field_sel` +1, wrapping FIELDS-1→0.
  - Left press: `field_sel` −1, wrapping 0→FIELDS-1.
  - Left and right pressed in the same cycle: no move.
  - A field move in a cycle suppresses any value strobe in that cycle.
  - Up press: `value_inc`. Down press: `value_dec`.
  - Up and down pressed (or held) together: neither strobe, and the repeat counter is cleared.
- **Activity** is any press, or any held key in EDIT. Activity clears the timeout counter; otherwise the counter increments, saturating at TIMEOUT-1.
- **Leaving EDIT** clears `field_sel` to 0 and clears the repeat and timeout counters.
- **Reset, at any time including mid-edit:**
  - State goes to IDLE.
  - `editing`, `value_inc`, `value_dec`, `commit`, `cancel` all go to 0, and `field_sel` goes to 0.
  - All counters and previous-sample registers go to 0, so a key held through reset release registers as a new press.

## Timing
- **Press latency:** a key is sampled high at edge k with a low previous sample. The corresponding strobe or state change is visible from edge k until edge k+1, i.e. exactly one cycle wide.
- **State entry:** `editing` rises at the same edge as the IDLE→EDIT transition.
- **State exit:** `editing` falls at the same edge that raises `commit` or `cancel`.
- **Strobe width:** no output strobe is ever wider than one cycle, except auto-repeat strobes, which are separate one-cycle pulses.
- **Timeout:** `cancel` is asserted TIMEOUT cycles after the last activity cycle.

## Configuration
- `EDIT_AUTO_REPEAT_EN` defined:
  - While exactly one of `key_up`/`key_down` is held in EDIT, a repeat strobe is emitted REPEAT_DELAY cycles after its press strobe.
  - After that, one repeat strobe every REPEAT_PERIOD cycles.
  - Releasing the key clears the repeat counter.
- `EDIT_AUTO_REPEAT_EN` undefined:
  - Exactly one strobe per press, regardless of hold length.
  - REPEAT_DELAY and REPEAT_PERIOD are unused, and the repeat counter is not built.

## Test plan
Parameters: FIELDS=4, REPEAT_DELAY=5, REPEAT_PERIOD=3, TIMEOUT=20.
- **Enter and commit:** set pressed in IDLE, then set pressed again 4 cycles later → `editing`=1 with `field_sel`=0, followed by one `commit` pulse, then `editing`=0.
- **Field wrap:** in EDIT, right ×4 → `field_sel` 1,2,3,0. Then left once → `field_sel`=3. Left and right pressed together → `field_sel` unchanged.
- **Auto-repeat:** `key_up` held 15 cycles, built with `EDIT_AUTO_REPEAT_EN` → `value_inc` pulses at press+0, +5, +8, +11, +14. Same stimulus built without the macro → a single pulse at press+0.
- **Conflicts:** up and down pressed in the same cycle → no strobe. Set and back pressed in the same cycle → `commit` only.
- **Timeout:** enter EDIT, then no keys for 20 cycles → one `cancel` pulse and `editing`=0. A key press at cycle 15 restarts the 20-cycle window.
- **Reset mid-edit:** reset asserted while in EDIT with `field_sel`=2 and `key_up` held → all outputs 0 immediately. After reset deasserts with `key_up` still high, no strobe is produced while in IDLE.

Source files
------------

// File: rtl/edit_sequencer.sv
// Alarm-time edit sequencer: key edge detection, IDLE/EDIT control, field selector, value strobes.
// Optional build macro EDIT_AUTO_REPEAT_EN adds auto-repeat of held up/down keys.
module edit_sequencer #(
    parameter int FIELDS        = 4,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int TIMEOUT       = 10000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      key_set,
    input  logic                      key_back,
    input  logic                      key_left,
    input  logic                      key_right,
    input  logic                      key_up,
    input  logic                      key_down,
    output logic                      editing,
    output logic [$clog2(FIELDS)-1:0] field_sel,
    output logic                      value_inc,
    output logic                      value_dec,
    output logic                      commit,
    output logic                      cancel
);

    localparam int FW = $clog2(FIELDS);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [FW-1:0] FIELD_MAX = FW'(FIELDS - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, EDIT = 1'b1} state_t;

    state_t          state_q;
    logic [5:0]      prev_q;
    logic [TW-1:0]   to_q;
    logic [FW-1:0]   field_q;
    logic            inc_q, dec_q, commit_q, cancel_q;

    logic [5:0] keys, press;
    logic       set_press, back_press, left_press, right_press, up_press, down_press;
    logic       up_only, down_only, activity, leave, rep_fire;

    assign keys  = {key_set, key_back, key_left, key_right, key_up, key_down};
    assign press = keys & ~prev_q;
    assign {set_press, back_press, left_press, right_press, up_press, down_press} = press;

    // Holding the opposite key blocks a strobe, so simultaneous up/down never adjusts the field.
    assign up_only   = key_up & ~key_down;
    assign down_only = key_down & ~key_up;
    assign activity  = |keys;
    assign leave     = (state_q == EDIT) && (set_press || back_press || to_q == TO_MAX);

`ifdef EDIT_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_q;
    logic          rep_phase_q;

    // First repeat waits REPEAT_DELAY from the press; later ones are REPEAT_PERIOD apart.
    assign rep_fire = (state_q == EDIT) && (up_only || down_only) && !(up_press || down_press) &&
                      (rep_phase_q ? (rep_q == RW'(REPEAT_PERIOD - 1))
                                   : (rep_q == RW'(REPEAT_DELAY - 1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
        end else if (state_q != EDIT || leave || !(up_only || down_only) || up_press || down_press) begin
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
        end else if (rep_fire) begin
            rep_q       <= '0;
            rep_phase_q <= 1'b1;
        end else begin
            rep_q <= rep_q + RW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            to_q     <= '0;
            field_q  <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            commit_q <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            prev_q   <= keys;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            commit_q <= 1'b0;
            cancel_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (set_press) begin
                        state_q <= EDIT;
                        field_q <= '0;
                        to_q    <= '0;
                    end
                end
                EDIT: begin
                    if (leave) begin
                        commit_q <= set_press;
                        cancel_q <= !set_press;
                        state_q  <= IDLE;
                        field_q  <= '0;
                        to_q     <= '0;
                    end else begin
                        // to_q < TO_MAX here, so the increment saturates at TO_MAX naturally.
                        to_q <= activity ? '0 : to_q + TW'(1);
                        if (right_press && !left_press) begin
                            field_q <= (field_q == FIELD_MAX) ? '0 : field_q + FW'(1);
                        end else if (left_press && !right_press) begin
                            field_q <= (field_q == '0) ? FIELD_MAX : field_q - FW'(1);
                        end else begin
                            inc_q <= up_only && (up_press || rep_fire);
                            dec_q <= down_only && (down_press || rep_fire);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign editing   = (state_q == EDIT);
    assign field_sel = field_q;
    assign value_inc = inc_q;
    assign value_dec = dec_q;
    assign commit    = commit_q;
    assign cancel    = cancel_q;

endmodule

// File: tb/tb_edit_sequencer.sv
// Directed self-checking bench for edit_sequencer (FIELDS=4, REPEAT_DELAY=5, REPEAT_PERIOD=3, TIMEOUT=20).
module tb_edit_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_set = 1'b0, key_back = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       key_up = 1'b0, key_down = 1'b0;
    logic       editing, value_inc, value_dec, commit, cancel;
    logic [1:0] field_sel;

    int n_checks = 0;
    int n_fail   = 0;

    edit_sequencer #(
        .FIELDS(4), .REPEAT_DELAY(5), .REPEAT_PERIOD(3), .TIMEOUT(20)
    ) dut (
        .clock(clock), .reset(reset),
        .key_set(key_set), .key_back(key_back), .key_left(key_left), .key_right(key_right),
        .key_up(key_up), .key_down(key_down),
        .editing(editing), .field_sel(field_sel), .value_inc(value_inc), .value_dec(value_dec),
        .commit(commit), .cancel(cancel)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enter_edit();
        key_set = 1'b1;
        tick();
        key_set = 1'b0;
    endtask

    task automatic leave_edit();
        key_back = 1'b1;
        tick();
        key_back = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({editing, field_sel, value_inc, value_dec, commit, cancel} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {editing, field_sel, value_inc, value_dec, commit, cancel});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (editing !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: editing=%b required 0", editing);
        end
        $display("test_reset done");
    endtask

    task automatic test_enter_commit();
        enter_edit();
        n_checks++;
        if (editing !== 1'b1 || field_sel !== 2'd0 || commit !== 1'b0) begin
            n_fail++;
            $display("FAIL enter: editing=%b field=%0d commit=%b required 1 0 0", editing, field_sel, commit);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (editing !== 1'b1 || commit !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_edit[%0d]: editing=%b commit=%b required 1 0", i, editing, commit);
            end
        end
        key_set = 1'b1;
        tick();
        n_checks++;
        if (commit !== 1'b1 || editing !== 1'b0) begin
            n_fail++;
            $display("FAIL commit: commit=%b editing=%b required 1 0", commit, editing);
        end
        key_set = 1'b0;
        tick();
        n_checks++;
        if (commit !== 1'b0 || editing !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_width: commit=%b editing=%b required 0 0", commit, editing);
        end
        $display("test_enter_commit done");
    endtask

    task automatic test_field_wrap();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
        enter_edit();
        tick();
        for (int i = 0; i < 4; i++) begin
            key_right = 1'b1;
            tick();
            key_right = 1'b0;
            n_checks++;
            if (field_sel !== exp_sel[i] || value_inc !== 1'b0) begin
                n_fail++;
                $display("FAIL right[%0d]: field=%0d required %0d", i, field_sel, exp_sel[i]);
            end
            tick();
        end
        key_left = 1'b1;
        tick();
        key_left = 1'b0;
        n_checks++;
        if (field_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL left_wrap: field=%0d required 3", field_sel);
        end
        tick();
        key_left = 1'b1;
        key_right = 1'b1;
        tick();
        key_left = 1'b0;
        key_right = 1'b0;
        n_checks++;
        if (field_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL left_right_both: field=%0d required 3", field_sel);
        end
        key_back = 1'b1;
        tick();
        key_back = 1'b0;
        n_checks++;
        if (cancel !== 1'b1 || field_sel !== 2'd0 || editing !== 1'b0) begin
            n_fail++;
            $display("FAIL back_cancel: cancel=%b field=%0d editing=%b required 1 0 0", cancel, field_sel, editing);
        end
        tick();
        $display("test_field_wrap done");
    endtask

    task automatic test_auto_repeat();
        logic exp_inc;
        enter_edit();
        tick();
        key_up = 1'b1;
        for (int j = 0; j < 15; j++) begin
            tick();
`ifdef EDIT_AUTO_REPEAT_EN
            exp_inc = (j == 0 || j == 5 || j == 8 || j == 11 || j == 14);
`else
            exp_inc = (j == 0);
`endif
            n_checks++;
            if (value_inc !== exp_inc || value_dec !== 1'b0) begin
                n_fail++;
                $display("FAIL repeat[+%0d]: inc=%b dec=%b required %b 0", j, value_inc, value_dec, exp_inc);
            end
        end
        key_up = 1'b0;
        tick();
        n_checks++;
        if (value_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_release: inc=%b required 0", value_inc);
        end
        leave_edit();
        $display("test_auto_repeat done");
    endtask

    task automatic test_conflicts();
        enter_edit();
        tick();
        key_up = 1'b1;
        key_down = 1'b1;
        tick();
        n_checks++;
        if (value_inc !== 1'b0 || value_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL up_down_both: inc=%b dec=%b required 0 0", value_inc, value_dec);
        end
        key_up = 1'b0;
        key_down = 1'b0;
        tick();
        key_down = 1'b1;
        tick();
        key_down = 1'b0;
        n_checks++;
        if (value_dec !== 1'b1 || value_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL down_press: dec=%b inc=%b required 1 0", value_dec, value_inc);
        end
        tick();
        n_checks++;
        if (value_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL down_width: dec=%b required 0", value_dec);
        end
        key_set = 1'b1;
        key_back = 1'b1;
        tick();
        key_set = 1'b0;
        key_back = 1'b0;
        n_checks++;
        if (commit !== 1'b1 || cancel !== 1'b0 || editing !== 1'b0) begin
            n_fail++;
            $display("FAIL set_back_both: commit=%b cancel=%b editing=%b required 1 0 0", commit, cancel, editing);
        end
        tick();
        $display("test_conflicts done");
    endtask

    task automatic test_timeout();
        enter_edit();
        for (int j = 1; j <= 20; j++) begin
            tick();
            n_checks++;
            if (cancel !== (j == 20) || editing !== (j != 20)) begin
                n_fail++;
                $display("FAIL timeout[%0d]: cancel=%b editing=%b required %b %b",
                         j, cancel, editing, (j == 20), (j != 20));
            end
        end
        tick();
        n_checks++;
        if (cancel !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_width: cancel=%b required 0", cancel);
        end
        enter_edit();
        for (int j = 1; j <= 14; j++) tick();
        key_right = 1'b1;
        tick();
        key_right = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            n_checks++;
            if (cancel !== (j == 20) || editing !== (j != 20)) begin
                n_fail++;
                $display("FAIL timeout_restart[%0d]: cancel=%b editing=%b required %b %b",
                         j, cancel, editing, (j == 20), (j != 20));
            end
        end
        tick();
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_edit();
        enter_edit();
        tick();
        for (int i = 0; i < 2; i++) begin
            key_right = 1'b1;
            tick();
            key_right = 1'b0;
            tick();
        end
        n_checks++;
        if (field_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_edit_field: field=%0d required 2", field_sel);
        end
        key_up = 1'b1;
        tick();
        n_checks++;
        if (value_inc !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_edit_inc: inc=%b required 1", value_inc);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({editing, field_sel, value_inc, value_dec, commit, cancel} !== 7'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 0000000",
                     {editing, field_sel, value_inc, value_dec, commit, cancel});
        end
        tick();
        tick();
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_checks++;
            if (value_inc !== 1'b0 || editing !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: inc=%b editing=%b required 0 0", j, value_inc, editing);
            end
        end
        key_up = 1'b0;
        tick();
        $display("test_reset_mid_edit done");
    endtask

    initial begin
        test_reset();
        test_enter_commit();
        test_field_wrap();
        test_auto_repeat();
        test_conflicts();
        test_timeout();
        test_reset_mid_edit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
